nios_system_mul_seq: RTL and testbench

NIOS_SYSTEM_MUL_SEQ -- requirements
Module: nios_system_mul_seq

---
 rtl/nios_system_mul_pkg.sv | 24 ++
 rtl/nios_system_mul16_cell.sv | 19 +
 rtl/nios_system_mul_seq.sv | 94 +++++++++
 tb/tb_nios_system_mul_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_mul_pkg.sv
// nios_system_mul_pkg: op encodings, FSM states, partial-product shifts and sign correction
package nios_system_mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSS = 2'b10,
        OP_MULXSU = 2'b11
    } op_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    // issue order: lo*lo, lo*hi, hi*lo, hi*hi
    localparam logic [5:0] PP_SHIFT [4] = '{6'd0, 6'd16, 6'd16, 6'd32};

    // Unsigned product plus this correction equals the signed product modulo 2^64
    function automatic logic [63:0] sign_corr(input op_t op, input logic [31:0] a, input logic [31:0] b);
        logic a_neg, b_neg;
        a_neg = (op == OP_MULXSS || op == OP_MULXSU) && a[31];
        b_neg = (op == OP_MULXSS) && b[31];
        return 64'd0 - ((a_neg ? {b, 32'd0} : 64'd0) + (b_neg ? {a, 32'd0} : 64'd0));
    endfunction

endpackage

// File: rtl/nios_system_mul16_cell.sv
// nios_system_mul16_cell: registered 16x16 unsigned multiplier, 1-cycle latency
// ports: clk, reset (sync, active-high), en (capture), a/b (16-bit operands), q (32-bit product)
module nios_system_mul16_cell (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= {16'd0, a} * {16'd0, b};
    end

endmodule

// File: rtl/nios_system_mul_seq.sv
// nios_system_mul_seq: sequential 32x32 multiplier built from one 16x16 cell
// ports: clk, reset (sync, active-high); start_valid/start_ready/start_op/src1/src2 request;
//        kill flush; result_valid/result_ready/result response; busy when not idle
module nios_system_mul_seq
    import nios_system_mul_pkg::*;
#(
    parameter bit MUL_SKIP_HI = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [1:0]  start_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        kill,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [31:0] result,
    output logic        busy
);

    state_t      state;
    op_t         op;
    logic [31:0] a, b;
    logic [1:0]  idx;
    logic [63:0] acc;
    logic [31:0] pp;
    logic [63:0] acc_sum;
    logic [1:0]  last_idx;

    // MUL only needs the low word, so hi*hi (shift 32) can be skipped
    assign last_idx    = (op == OP_MUL && MUL_SKIP_HI) ? 2'd2 : 2'd3;
    // cell output always belongs to the previous issue slot
    assign acc_sum     = acc + ({32'd0, pp} << PP_SHIFT[idx - 2'd1]);
    assign start_ready = state == S_IDLE && !reset;
    assign busy        = state != S_IDLE;

    nios_system_mul16_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .en    (state == S_ISSUE),
        .a     (idx[1] ? a[31:16] : a[15:0]),
        .b     (idx[0] ? b[31:16] : b[15:0]),
        .q     (pp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            op           <= OP_MUL;
            a            <= '0;
            b            <= '0;
            idx          <= '0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start_valid && !kill) begin
                    op    <= op_t'(start_op);
                    a     <= src1;
                    b     <= src2;
                    idx   <= '0;
                    acc   <= sign_corr(op_t'(start_op), src1, src2);
                    state <= S_ISSUE;
                end
                S_ISSUE: if (kill)
                    state <= S_IDLE;
                else begin
                    if (idx != 2'd0)
                        acc <= acc_sum;
                    idx <= idx + 2'd1;
                    if (idx == last_idx)
                        state <= S_DRAIN;
                end
                S_DRAIN: if (kill)
                    state <= S_IDLE;
                else begin
                    acc          <= acc_sum;
                    result       <= (op == OP_MUL) ? acc_sum[31:0] : acc_sum[63:32];
                    result_valid <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE: if (kill || result_ready) begin
                    result_valid <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_system_mul_seq.sv
// tb_nios_system_mul_seq: directed vectors, corner sequences and random ops against a 64-bit model
module tb_nios_system_mul_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [1:0]  start_op = 2'd0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        kill = 1'b0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int passed = 0;
    int total  = 0;

    nios_system_mul_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_op     (start_op),
        .src1         (src1),
        .src2         (src2),
        .kill         (kill),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex, ey, p;
        ex = (op == 2'd2 || op == 2'd3) ? {{32{x[31]}}, x} : {32'd0, x};
        ey = (op == 2'd2) ? {{32{y[31]}}, y} : {32'd0, y};
        p  = ex * ey;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // accept one op, count edges to result_valid, then complete the handshake
    task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        start_valid = 1'b1;
        start_op    = op;
        src1        = x;
        src2        = y;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        src1        = $urandom;
        src2        = $urandom;
        lat = 0;
        while (!result_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res, held;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          lat;

        vecs[0] = '{2'd0, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000};
        vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2] = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[3] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[4] = '{2'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[5] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[6] = '{2'd0, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001};
        vecs[7] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[9] = '{2'd1, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_start_ready", start_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_start_ready", start_ready, 1);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_valid", result_valid, 0);
        chk("post_reset_result", result, 0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, (vecs[i].op == 2'd0) ? 4 : 5);
        end

        // kill in IDLE blocks acceptance
        @(negedge clk);
        start_valid = 1'b1;
        kill        = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        kill        = 1'b0;
        chk("kill_idle_busy", busy, 0);

        // backpressure: result and status stay frozen while result_ready is low
        @(negedge clk);
        start_valid = 1'b1;
        start_op    = 2'd1;
        src1        = 32'hFFFF_FFFF;
        src2        = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        lat = 0;
        while (!result_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_latency", lat, 5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d", i), {result_valid, start_ready, busy, result},
                {1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE});
        end
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk("bp_release", {result_valid, start_ready, busy}, 3'b010);

        // kill while issuing idx=1
        @(negedge clk);
        start_valid = 1'b1;
        start_op    = 2'd0;
        src1        = 32'h1234_5678;
        src2        = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_issue_state", {result_valid, start_ready, busy}, 3'b010);
        held = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            held = held | {31'd0, result_valid};
        end
        chk("kill_issue_no_valid", held, 0);
        run_op(2'd1, 32'd3, 32'd5, res, lat);
        chk("after_kill_mulxuu", res, 32'h0000_0000);
        run_op(2'd0, 32'd3, 32'd5, res, lat);
        chk("after_kill_mul", res, 32'h0000_000F);

        // kill in DONE returns to IDLE
        @(negedge clk);
        start_valid = 1'b1;
        start_op    = 2'd0;
        src1        = 32'd9;
        src2        = 32'd9;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("done_valid", {result_valid, result}, {1'b1, 32'd81});
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_done", {result_valid, start_ready, busy}, 3'b010);

        // reset pulse while in DRAIN
        @(negedge clk);
        start_valid = 1'b1;
        start_op    = 2'd0;
        src1        = 32'd7;
        src2        = 32'd6;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_busy", busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_reset_outputs", {result_valid, start_ready, busy, result}, 35'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("drain_reset_release", {start_ready, busy}, 2'b10);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_reset_no_valid", result_valid, 0);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
            rb  = (i % 6 == 1) ? 32'hFFFF_FFFF : $urandom;
            run_op(rop, ra, rb, res, lat);
            chk($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb), res, model(rop, ra, rb));
            chk($sformatf("rand%0d_latency", i), lat, (rop == 2'd0) ? 4 : 5);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
